// File: rtl/gray_bin_conv_pipe.sv
// Gray/binary code converter with a single registered output stage and
// valid/ready handshaking on both sides. Optionally watches consecutive
// Gray inputs and raises a sticky flag when they differ in other than one bit.
//
// Optional feature macro: GBC_PARITY_EN adds out_parity, the XOR-reduction
// of out_data, registered alongside it.
module gray_bin_conv_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHK_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             step_err,
  input  logic             clr_err
`ifdef GBC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             accept;
  logic [WIDTH-1:0] conv_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Conversion of the incoming word in the direction selected by mode.
  always_comb begin
    conv_data = '0;
    if (mode) begin
      conv_data = in_data ^ (in_data >> 1);
    end else begin
      conv_data[WIDTH-1] = in_data[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        conv_data[i] = conv_data[i+1] ^ in_data[i];
      end
    end
  end

  // Output register: load on acceptance, drop after a transfer, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= conv_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GBC_PARITY_EN
  // Parity travels with the data word it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^conv_data;
    end
  end
`endif

  generate
    if (CHK_STEP != 0) begin : g_chk
      localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

      logic [WIDTH-1:0] prev;
      logic             prev_vld;
      logic [WIDTH-1:0] diff;
      logic             not_one_step;
      logic             err_q;

      assign diff         = in_data ^ prev;
      // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
      assign not_one_step = (diff == '0) || ((diff & (diff - ONE)) != '0);

      // Track the last Gray word and flag non-unit steps; a clear overrides a
      // violation in the same cycle, but the word is still recorded.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prev     <= '0;
          prev_vld <= 1'b0;
          err_q    <= 1'b0;
        end else begin
          if (accept && !mode) begin
            prev <= in_data;
          end
          if (clr_err) begin
            err_q    <= 1'b0;
            prev_vld <= 1'b0;
          end else if (accept) begin
            if (!mode) begin
              prev_vld <= 1'b1;
              if (prev_vld && not_one_step) begin
                err_q <= 1'b1;
              end
            end else begin
              prev_vld <= 1'b0;
            end
          end
        end
      end

      assign step_err = err_q;
    end else begin : g_nochk
      logic unused_clr;
      assign unused_clr = clr_err;
      assign step_err   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe at WIDTH=4, CHK_STEP=1.
module tb_gray_bin_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n, mode, in_valid, in_ready, out_valid, out_ready, step_err, clr_err;
  logic [3:0] in_data, out_data;
`ifdef GBC_PARITY_EN
  logic       out_parity;
`endif

  int nvec = 0;
  int nerr = 0;

  gray_bin_conv_pipe #(.WIDTH(4), .CHK_STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .step_err  (step_err),
    .clr_err   (clr_err)
`ifdef GBC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [3:0] din;
    logic [3:0] dout;
    logic       par;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_par(input logic exp);
`ifdef GBC_PARITY_EN
    chk("out_parity", {31'd0, out_parity}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unexpected parity");
`endif
  endtask

  task automatic send(input logic m, input logic [3:0] d);
    mode = m; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 4'b1101, 4'b1001, 1'b0};
    vt[1]  = '{1'b0, 4'b0110, 4'b0100, 1'b1};
    vt[2]  = '{1'b0, 4'b1111, 4'b1010, 1'b0};
    vt[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    vt[4]  = '{1'b0, 4'b1000, 4'b1111, 1'b0};
    vt[5]  = '{1'b0, 4'b0001, 4'b0001, 1'b1};
    vt[6]  = '{1'b1, 4'b1001, 4'b1101, 1'b1};
    vt[7]  = '{1'b1, 4'b0110, 4'b0101, 1'b0};
    vt[8]  = '{1'b1, 4'b1111, 4'b1000, 1'b1};
    vt[9]  = '{1'b1, 4'b0100, 4'b0110, 1'b0};
    vt[10] = '{1'b1, 4'b0011, 4'b0010, 1'b1};

    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    out_ready = 1'b1; clr_err = 1'b0;
    tick(); tick();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", {28'd0, out_data}, 32'd0);
    chk("rst step_err", {31'd0, step_err}, 32'd0);
    chk_par(1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back table vectors at full throughput
    for (int i = 0; i < 11; i++) begin
      mode = vt[i].mode; in_data = vt[i].din; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("tbl out_valid", {31'd0, out_valid}, 32'd1);
      chk($sformatf("tbl[%0d] out_data", i), {28'd0, out_data}, {28'd0, vt[i].dout});
      chk_par(vt[i].par);
    end
    in_valid = 1'b0;
    clr_pulse();
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);
    chk("post-clr step_err", {31'd0, step_err}, 32'd0);

    // Exhaustive round trip
    for (int v = 0; v < 16; v++) begin
      logic [3:0] w, g;
      w = 4'(v);
      g = w ^ {1'b0, w[3:1]};
      send(1'b1, w);
      chk("b2g", {28'd0, out_data}, {28'd0, g});
      send(1'b0, out_data);
      chk("roundtrip", {28'd0, out_data}, {28'd0, w});
    end
    clr_pulse();

    // Backpressure: hold for three cycles, then release with no bubble
    send(1'b0, 4'b0110);
    chk("bp load", {28'd0, out_data}, 32'h4);
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; in_data = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp hold data", {28'd0, out_data}, 32'h4);
      chk("bp hold valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp next data", {28'd0, out_data}, 32'h5);
    chk("bp next valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp drained", {31'd0, out_valid}, 32'd0);

    // Step check
    clr_pulse();
    send(1'b0, 4'b0000); chk("step 0000", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b0001); chk("step 0001", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b0011); chk("step 0011", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b0000); chk("step jump", {31'd0, step_err}, 32'd1);
    tick(); tick();
    chk("step sticky", {31'd0, step_err}, 32'd1);
    clr_pulse();
    chk("step clr", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b1111); chk("step unchecked", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b1111); chk("step repeat", {31'd0, step_err}, 32'd1);
    clr_err = 1'b1;
    send(1'b0, 4'b1111);
    clr_err = 1'b0;
    chk("step clr wins", {31'd0, step_err}, 32'd0);

    // Mode switch clears the step history
    clr_pulse();
    send(1'b0, 4'b0000); chk("ms 0000", {31'd0, step_err}, 32'd0);
    send(1'b1, 4'b0101); chk("ms b2g", {28'd0, out_data}, 32'h7);
    chk("ms mode1", {31'd0, step_err}, 32'd0);
    send(1'b0, 4'b1111); chk("ms 1111", {31'd0, step_err}, 32'd0);

    // Reset mid-operation with a held word and the flag set
    send(1'b0, 4'b0000);
    chk("pre-rst step_err", {31'd0, step_err}, 32'd1);
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; in_data = 4'b1010;
    tick();
    chk("pre-rst held", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid-rst out_data", {28'd0, out_data}, 32'd0);
    chk("mid-rst step_err", {31'd0, step_err}, 32'd0);
    tick();
    chk("no accept in rst", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    send(1'b0, 4'b0000);
    chk("post-rst first word", {31'd0, step_err}, 32'd0);
    chk("post-rst data", {28'd0, out_data}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
